// File: rtl/qspi_reg_seq.sv
// qspi_reg_seq: byte-register access sequencer in front of spi_axi_if.
// Takes one register command at a time and issues the matching single-beat
// AXI write or read to the QSPI register window. Byte writes are placed on
// the right lane with a one-hot strobe, and byte reads are taken from the
// right lane. A busy-poll loop can optionally follow each write.
//
// Build option: define QSPI_SEQ_POLL_EN to build the busy-poll counter and
// honour the poll bit. When it is undefined, req_cmd[13] has no effect and a
// write always completes straight after its write response.
module qspi_reg_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h1fff0300,
  parameter int          DW        = 128,
  parameter logic [3:0]  STAT_OFF  = 4'h2,
  parameter int          POLL_BIT  = 0,
  parameter int          POLL_MAX  = 255
) (
  input  logic            aclk,
  input  logic            aresetn,
  // requester side
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [13:0]     req_cmd,
  output logic            rsp_valid,
  output logic [7:0]      rsp_data,
  output logic            rsp_err,
  // AXI write address / data / response
  output logic [31:0]     spi_if_awaddr,
  output logic            spi_if_awvalid,
  input  logic            spi_if_awready,
  output logic [DW-1:0]   spi_if_wdata,
  output logic [DW/8-1:0] spi_if_wstrb,
  output logic            spi_if_wvalid,
  input  logic            spi_if_wready,
  input  logic [1:0]      spi_if_bresp,
  input  logic            spi_if_bvalid,
  output logic            spi_if_bready,
  // AXI read address / data
  output logic [31:0]     spi_if_araddr,
  output logic            spi_if_arvalid,
  input  logic            spi_if_arready,
  input  logic [DW-1:0]   spi_if_rdata,
  input  logic [1:0]      spi_if_rresp,
  input  logic            spi_if_rvalid,
  output logic            spi_if_rready
);

  typedef enum logic [2:0] {IDLE, WR, BRESP, RD, RDATA, RESP} state_t;

  localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);

`ifdef QSPI_SEQ_POLL_EN
  localparam bit POLL_EN = 1'b1;
`else
  localparam bit POLL_EN = 1'b0;
`endif

  state_t     state, state_nx;

  // latched command fields
  logic       op_poll;
  logic [3:0] op_off;
  logic [7:0] op_wdata;

  logic       aw_done, w_done;  // write-channel handshakes already taken
  logic       poll_mode;        // reads now target the status register

  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic       accept;
  logic [3:0] rd_off;
  logic [7:0] rd_byte;
  logic       b_err, r_err;
  logic       busy, poll_live, poll_last, poll_again, poll_timeout;
  logic [7:0] poll_cnt_inc;

  assign accept  = (state == IDLE) && req_valid;
  assign aw_hs   = spi_if_awvalid && spi_if_awready;
  assign w_hs    = spi_if_wvalid  && spi_if_wready;
  assign b_hs    = spi_if_bvalid  && spi_if_bready;
  assign ar_hs   = spi_if_arvalid && spi_if_arready;
  assign r_hs    = spi_if_rvalid  && spi_if_rready;

  assign b_err   = (spi_if_bresp != 2'b00);
  assign r_err   = (spi_if_rresp != 2'b00);
  assign rd_off  = poll_mode ? STAT_OFF : op_off;
  assign rd_byte = spi_if_rdata[{rd_off, 3'b000} +: 8];

  // Poll decision for the status byte arriving this cycle.
  assign busy         = rd_byte[POLL_BIT];
  assign poll_live    = poll_mode && busy && !r_err;
  assign poll_last    = (poll_cnt_inc == POLL_LIMIT);
  assign poll_again   = poll_live && !poll_last;
  assign poll_timeout = poll_live && poll_last;

`ifdef QSPI_SEQ_POLL_EN
  logic [7:0] poll_cnt;

  assign poll_cnt_inc = poll_cnt + 8'd1;

  // Count status reads issued since the command was accepted.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      poll_cnt <= 8'd0;
    end else if (accept) begin
      poll_cnt <= 8'd0;
    end else if ((state == RDATA) && r_hs) begin
      poll_cnt <= poll_cnt_inc;
    end
  end
`else
  // Without a counter every status read is treated as the last one; poll
  // mode is never entered in this build, so this value is never consulted.
  assign poll_cnt_inc = POLL_LIMIT;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decision.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (req_valid) state_nx = req_cmd[12] ? WR : RD;
      WR:    if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = BRESP;
      BRESP: if (b_hs) state_nx = (b_err || !op_poll) ? RESP : RD;
      RD:    if (ar_hs) state_nx = RDATA;
      RDATA: if (r_hs) state_nx = poll_again ? RD : RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command latch, write-handshake tracking, poll mode and response capture.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      op_poll   <= 1'b0;
      op_off    <= 4'd0;
      op_wdata  <= 8'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      poll_mode <= 1'b0;
      rsp_data  <= 8'd0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      op_poll   <= req_cmd[13] & POLL_EN;
      op_off    <= req_cmd[11:8];
      op_wdata  <= req_cmd[7:0];
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      poll_mode <= 1'b0;
      rsp_data  <= 8'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == WR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if ((state == BRESP) && b_hs) begin
        rsp_err <= b_err;
        if (!b_err && op_poll) poll_mode <= 1'b1;
      end
      if ((state == RDATA) && r_hs) begin
        rsp_data <= rd_byte;
        rsp_err  <= r_err || poll_timeout;
      end
    end
  end

  // Bus and requester outputs decoded from the current state.
  always_comb begin
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    spi_if_awaddr  = 32'd0;
    spi_if_awvalid = 1'b0;
    spi_if_wdata   = '0;
    spi_if_wstrb   = '0;
    spi_if_wvalid  = 1'b0;
    spi_if_bready  = 1'b0;
    spi_if_araddr  = 32'd0;
    spi_if_arvalid = 1'b0;
    spi_if_rready  = 1'b0;
    unique case (state)
      IDLE: req_ready = 1'b1;
      WR: begin
        spi_if_awaddr  = BASE_ADDR + {28'd0, op_off};
        spi_if_awvalid = !aw_done;
        spi_if_wdata   = {{(DW-8){1'b0}}, op_wdata} << {op_off, 3'b000};
        spi_if_wstrb   = {{(DW/8-1){1'b0}}, 1'b1} << op_off;
        spi_if_wvalid  = !w_done;
      end
      BRESP: spi_if_bready = 1'b1;
      RD: begin
        spi_if_araddr  = BASE_ADDR + {28'd0, rd_off};
        spi_if_arvalid = 1'b1;
      end
      RDATA: spi_if_rready = 1'b1;
      RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qspi_reg_seq.sv
// tb_qspi_reg_seq: randomized scoreboard bench for qspi_reg_seq.
// A stimulus process issues commands and pushes the response predicted by a
// behavioural model; an AXI slave process answers the bus and checks the
// request fields; a monitor pops and compares whenever rsp_valid is seen.
module tb_qspi_reg_seq;

  localparam logic [31:0] BASE = 32'h1fff0300;
  localparam int          DW   = 128;
  localparam logic [3:0]  STAT = 4'h2;
  localparam int          PMAX = 4;

`ifdef QSPI_SEQ_POLL_EN
  localparam bit POLL_ON = 1'b1;
`else
  localparam bit POLL_ON = 1'b0;
`endif

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [13:0]     req_cmd = '0;
  logic            rsp_valid;
  logic [7:0]      rsp_data;
  logic            rsp_err;
  logic [31:0]     spi_if_awaddr;
  logic            spi_if_awvalid;
  logic            spi_if_awready = 1'b0;
  logic [DW-1:0]   spi_if_wdata;
  logic [DW/8-1:0] spi_if_wstrb;
  logic            spi_if_wvalid;
  logic            spi_if_wready = 1'b0;
  logic [1:0]      spi_if_bresp = 2'b00;
  logic            spi_if_bvalid = 1'b0;
  logic            spi_if_bready;
  logic [31:0]     spi_if_araddr;
  logic            spi_if_arvalid;
  logic            spi_if_arready = 1'b0;
  logic [DW-1:0]   spi_if_rdata = '0;
  logic [1:0]      spi_if_rresp = 2'b00;
  logic            spi_if_rvalid = 1'b0;
  logic            spi_if_rready;

  qspi_reg_seq #(
    .BASE_ADDR(BASE), .DW(DW), .STAT_OFF(STAT), .POLL_BIT(0), .POLL_MAX(PMAX)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .spi_if_awaddr(spi_if_awaddr), .spi_if_awvalid(spi_if_awvalid),
    .spi_if_awready(spi_if_awready),
    .spi_if_wdata(spi_if_wdata), .spi_if_wstrb(spi_if_wstrb),
    .spi_if_wvalid(spi_if_wvalid), .spi_if_wready(spi_if_wready),
    .spi_if_bresp(spi_if_bresp), .spi_if_bvalid(spi_if_bvalid),
    .spi_if_bready(spi_if_bready),
    .spi_if_araddr(spi_if_araddr), .spi_if_arvalid(spi_if_arvalid),
    .spi_if_arready(spi_if_arready),
    .spi_if_rdata(spi_if_rdata), .spi_if_rresp(spi_if_rresp),
    .spi_if_rvalid(spi_if_rvalid), .spi_if_rready(spi_if_rready)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         reads;
    int         bs;
  } exp_t;

  exp_t exp_q[$];

  // Per-command plan shared between stimulus and slave.
  int          mode = 0;  // 0 zero-wait, 1 random waits, 2 wready before awready
  logic [1:0]  plan_bresp = 2'b00;
  int          plan_b_delay = 0;
  logic [7:0]  plan_st[$];
  logic [1:0]  plan_rr[$];
  logic [3:0]  plan_rd_off = 4'd0;
  logic [31:0] exp_awaddr = '0, exp_araddr = '0;
  logic [127:0] exp_wdata = '0;
  logic [15:0] exp_wstrb = '0;

  int ar_cnt = 0, b_cnt = 0;

  // Slave state
  bit aw_done_s, w_done_s, b_arm, r_arm, b_fire, r_fire;
  bit aw_pend, w_pend, ar_pend;
  bit aw_hs, w_hs, ar_hs;
  int b_wait, r_wait, aw_age;
  logic [31:0]  aw_hold, ar_hold;
  logic [127:0] w_hold;

  // AXI slave: all decisions at the falling edge, so each valid/ready pair
  // seen here is exactly what the next rising edge will sample.
  always begin
    @(negedge aclk);
    if (!aresetn) begin
      spi_if_awready = 0; spi_if_wready = 0; spi_if_arready = 0;
      spi_if_bvalid = 0; spi_if_rvalid = 0; spi_if_rdata = '0;
      aw_done_s = 0; w_done_s = 0; b_arm = 0; r_arm = 0; b_fire = 0; r_fire = 0;
      aw_pend = 0; w_pend = 0; ar_pend = 0; aw_age = 0;
      ar_cnt = 0; b_cnt = 0;
    end else begin
      if (aw_pend) check("aw_held", {spi_if_awvalid, spi_if_awaddr}, {1'b1, aw_hold});
      if (w_pend)  check("w_held",  {spi_if_wvalid, spi_if_wdata}, {1'b1, w_hold});
      if (ar_pend) check("ar_held", {spi_if_arvalid, spi_if_araddr}, {1'b1, ar_hold});
      if (mode == 2 && w_done_s && !aw_done_s)
        check("skew_wvalid_first", {spi_if_awvalid, spi_if_wvalid}, 2'b10);

      if (b_fire) spi_if_bvalid = 0;
      if (r_fire) begin spi_if_rvalid = 0; spi_if_rdata = '0; end

      if (b_arm) begin
        if (b_wait == 0) begin
          spi_if_bvalid = 1; spi_if_bresp = plan_bresp; b_arm = 0;
        end else b_wait--;
      end
      if (r_arm) begin
        if (r_wait == 0) begin
          logic [7:0] st;
          st = (plan_st.size() != 0) ? plan_st.pop_front() : 8'h00;
          spi_if_rresp = (plan_rr.size() != 0) ? plan_rr.pop_front() : 2'b00;
          spi_if_rdata = {$urandom, $urandom, $urandom, $urandom};
          spi_if_rdata[int'(plan_rd_off) * 8 +: 8] = st;
          spi_if_rvalid = 1; r_arm = 0;
        end else r_wait--;
      end

      aw_age = spi_if_awvalid ? aw_age + 1 : 0;
      case (mode)
        0: begin
          spi_if_awready = spi_if_awvalid;
          spi_if_wready  = spi_if_wvalid;
          spi_if_arready = spi_if_arvalid;
        end
        1: begin
          spi_if_awready = spi_if_awvalid && ($urandom_range(0, 2) != 0);
          spi_if_wready  = spi_if_wvalid  && ($urandom_range(0, 2) != 0);
          spi_if_arready = spi_if_arvalid && ($urandom_range(0, 2) != 0);
        end
        default: begin
          spi_if_awready = spi_if_awvalid && (aw_age >= 2);
          spi_if_wready  = spi_if_wvalid;
          spi_if_arready = spi_if_arvalid;
        end
      endcase

      aw_hs  = spi_if_awvalid && spi_if_awready;
      w_hs   = spi_if_wvalid && spi_if_wready;
      ar_hs  = spi_if_arvalid && spi_if_arready;
      b_fire = spi_if_bvalid && spi_if_bready;
      r_fire = spi_if_rvalid && spi_if_rready;

      if (aw_hs) begin
        check("awaddr", spi_if_awaddr, exp_awaddr);
        aw_done_s = 1;
      end
      if (w_hs) begin
        check("wdata", spi_if_wdata, exp_wdata);
        check("wstrb", spi_if_wstrb, exp_wstrb);
        w_done_s = 1;
      end
      if ((aw_hs || w_hs) && aw_done_s && w_done_s) begin
        b_arm = 1; b_wait = plan_b_delay;
      end
      if (ar_hs) begin
        check("araddr", spi_if_araddr, exp_araddr);
        ar_cnt++;
        r_arm = 1; r_wait = (mode == 1) ? $urandom_range(0, 2) : 0;
      end
      if (b_fire) begin
        b_cnt++; aw_done_s = 0; w_done_s = 0;
      end

      aw_pend = spi_if_awvalid && !aw_hs; aw_hold = spi_if_awaddr;
      w_pend  = spi_if_wvalid && !w_hs;   w_hold  = spi_if_wdata;
      ar_pend = spi_if_arvalid && !ar_hs; ar_hold = spi_if_araddr;
    end
  end

  // Monitor: compare every presented response against the scoreboard.
  always begin
    @(negedge aclk);
    if (aresetn && rsp_valid) begin
      check("rsp_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", rsp_err, e.err);
        check("status_reads", ar_cnt, e.reads);
        check("b_handshakes", b_cnt, e.bs);
      end
      ar_cnt = 0; b_cnt = 0;
    end
  end

  // Issue one command. plan_st/plan_rr hold the bytes/resps the slave will
  // return for each read; the expected response is derived from them here.
  task automatic run_cmd(input bit poll, input bit wr, input logic [3:0] off,
                         input logic [7:0] wd, input logic [1:0] bresp,
                         input int bdelay, input bit rst_mid);
    exp_t       e;
    logic [7:0] sts[$];
    logic [1:0] rrs[$];
    int         lat, lim;
    sts = plan_st; rrs = plan_rr;
    e.data = 8'h00; e.err = 1'b0; e.reads = 0; e.bs = wr ? 1 : 0;
    if (wr) begin
      e.err = (bresp != 2'b00);
      if (poll && POLL_ON && !e.err) begin
        for (int i = 0; i < PMAX; i++) begin
          e.reads++;
          e.data = sts[i];
          if (rrs[i] != 2'b00) begin e.err = 1'b1; break; end
          if (!sts[i][0]) break;
          if (e.reads == PMAX) e.err = 1'b1;
        end
      end
    end else begin
      e.reads = 1; e.data = sts[0]; e.err = (rrs[0] != 2'b00);
    end

    exp_awaddr   = BASE + 32'(off);
    exp_wdata    = 128'(wd) << (8 * int'(off));
    exp_wstrb    = 16'd1 << off;
    plan_rd_off  = wr ? STAT : off;
    exp_araddr   = BASE + 32'(plan_rd_off);
    plan_bresp   = bresp;
    plan_b_delay = bdelay;

    lim = 0;
    while (!req_ready && lim < 50) begin @(negedge aclk); lim++; end
    check("req_ready_idle", req_ready, 1'b1);
    req_cmd = {poll, wr, off, wd}; req_valid = 1'b1;
    @(posedge aclk);
    exp_q.push_back(e);
    @(negedge aclk);
    req_valid = 1'b0; req_cmd = '0;

    if (rst_mid) begin
      lim = 0;
      while (!spi_if_bready && lim < 50) begin @(negedge aclk); lim++; end
      check("reached_bresp", spi_if_bready, 1'b1);
      aresetn = 1'b0;
      @(posedge aclk); #1;
      check("rst_mid_valids", {spi_if_awvalid, spi_if_wvalid, spi_if_bready,
                               spi_if_arvalid, spi_if_rready, rsp_valid}, 6'd0);
      check("rst_mid_req_ready", req_ready, 1'b1);
      void'(exp_q.pop_back());
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      plan_st.delete(); plan_rr.delete();
      return;
    end

    lat = 1;
    while (!rsp_valid && lat < 400) begin @(negedge aclk); lat++; end
    check("rsp_seen", rsp_valid, 1'b1);
    if (mode == 0 && bdelay == 0)
      check("latency", lat, wr ? 3 + 2 * e.reads : 3);
    @(negedge aclk);
    plan_st.delete(); plan_rr.delete();
  endtask

  task automatic fill_status(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
    plan_st = '{a, b, c, d};
    plan_rr = '{2'b00, 2'b00, 2'b00, 2'b00};
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge aclk);
    check("reset_valids", {spi_if_awvalid, spi_if_wvalid, spi_if_bready,
                           spi_if_arvalid, spi_if_rready, rsp_valid}, 6'd0);
    check("reset_addrs", {spi_if_awaddr, spi_if_araddr}, 64'd0);
    check("reset_wdata", {spi_if_wdata, spi_if_wstrb}, 144'd0);
    check("reset_rsp", {rsp_data, rsp_err}, 9'd0);
    check("reset_req_ready", req_ready, 1'b1);
    aresetn = 1'b1;
    @(negedge aclk);

    // plain write, offset 3
    mode = 0;
    fill_status(8'h00, 8'h00, 8'h00, 8'h00);
    run_cmd(1'b0, 1'b1, 4'd3, 8'h80, 2'b00, 0, 1'b0);
    // plain read, offset 2
    plan_st = '{8'h5A}; plan_rr = '{2'b00};
    run_cmd(1'b0, 1'b0, 4'd2, 8'h00, 2'b00, 0, 1'b0);
    // read from the top lane with a slave error
    plan_st = '{8'hC3}; plan_rr = '{2'b10};
    run_cmd(1'b0, 1'b0, 4'd15, 8'h00, 2'b00, 0, 1'b0);
    // polled write: busy, busy, idle
    fill_status(8'h01, 8'h01, 8'h00, 8'h00);
    run_cmd(1'b1, 1'b1, 4'd0, 8'h01, 2'b00, 0, 1'b0);
    // poll timeout: always busy
    fill_status(8'h01, 8'h01, 8'h01, 8'h01);
    run_cmd(1'b1, 1'b1, 4'd5, 8'h3C, 2'b00, 0, 1'b0);
    // write error on a polled write: no status read
    fill_status(8'h01, 8'h01, 8'h01, 8'h01);
    run_cmd(1'b1, 1'b1, 4'd9, 8'hA5, 2'b10, 0, 1'b0);
    // wready one cycle ahead of awready
    mode = 2;
    fill_status(8'h00, 8'h00, 8'h00, 8'h00);
    run_cmd(1'b0, 1'b1, 4'd7, 8'h42, 2'b00, 0, 1'b0);
    // reset while waiting for the write response, then a normal command
    mode = 0;
    fill_status(8'h00, 8'h00, 8'h00, 8'h00);
    run_cmd(1'b1, 1'b1, 4'd4, 8'h11, 2'b00, 6, 1'b1);
    plan_st = '{8'h96}; plan_rr = '{2'b00};
    run_cmd(1'b0, 1'b0, 4'd11, 8'h00, 2'b00, 0, 1'b0);

    // randomized traffic with random slave waits
    mode = 1;
    for (int n = 0; n < 60; n++) begin
      logic [1:0] br;
      plan_st.delete(); plan_rr.delete();
      for (int k = 0; k < PMAX; k++) begin
        logic [7:0] st;
        st = 8'($urandom);
        st[0] = ($urandom_range(0, 4) < 3);
        plan_st.push_back(st);
        plan_rr.push_back(($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
      end
      br = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_cmd(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
              br, $urandom_range(0, 3), 1'b0);
    end

    repeat (4) @(negedge aclk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_reg_seq.md
# qspi_reg_seq

Byte-register access sequencer in front of `spi_axi_if`. It accepts one register command at a time from a simple requester (CPU shim or boot loader) and issues the matching single-beat AXI write or read to the QSPI register window. Byte writes use the correct strobe and lane, byte reads are extracted from the correct lane, and an optional busy-poll loop can follow each write.

## Interface
- `BASE_ADDR`, 32'h1fff0300, AXI address of register window offset 0
- `DW`, 128, AXI data width (16 byte lanes)
- `STAT_OFF`, 4'h2, byte offset of the status register polled after a write
- `POLL_BIT`, 0, bit of the status byte meaning "busy"
- `POLL_MAX`, 255, maximum status reads per poll (1..255)
- `aclk` in 1 clock, all logic on rising edge
- `aresetn` in 1 synchronous active-low reset
- `req_valid` in 1 command valid
- `req_ready` out 1 command accepted when high with `req_valid`
- `req_cmd` in 14 {poll[13], write[12], offset[11:8], wdata[7:0]}
- `rsp_valid` out 1 one-cycle response pulse; there is no backpressure
- `rsp_data` out 8 read byte (reads), last status byte (polled writes), else 0
- `rsp_err` out 1 slave error or poll timeout
- `spi_if_awaddr` out 32, `spi_if_awvalid` out 1, `spi_if_awready` in 1
- `spi_if_wdata` out DW, `spi_if_wstrb` out DW/8, `spi_if_wvalid` out 1, `spi_if_wready` in 1
- `spi_if_bresp` in 2, `spi_if_bvalid` in 1, `spi_if_bready` out 1
- `spi_if_araddr` out 32, `spi_if_arvalid` out 1, `spi_if_arready` in 1
- `spi_if_rdata` in DW, `spi_if_rresp` in 2, `spi_if_rvalid` in 1, `spi_if_rready` out 1
- The parent ties the remaining AXI fields to constants: len=0, size=0, burst=0, lock=0, cache=0, wlast=1, ids fixed.

## Operation
- States: IDLE, WR, BRESP, RD, RDATA, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch `req_cmd`, clear the poll counter, and go to WR (write=1) or RD (write=0).
- WR: `awaddr`=BASE_ADDR+offset; `wdata`=wdata<<(8*offset); `wstrb`=1<<offset.
  - `awvalid` and `wvalid` rise together. Each drops on its own handshake.
  - Go to BRESP once both handshakes are done. They may complete in either order or in the same cycle.
- BRESP: `bready`=1. On `bvalid`, set err=(bresp!=0).
  - If err=1 or poll=0, go to RESP.
  - Otherwise go to RD with the address forced to STAT_OFF (poll mode).
- RD: `araddr`=BASE_ADDR+offset (STAT_OFF in poll mode). `arvalid` is held until `arready`, then go to RDATA.
- RDATA: `rready`=1. On `rvalid`, capture `rdata[8*off +: 8]` and set err=(rresp!=0), then increment the poll counter.
  - Poll mode, byte[POLL_BIT]=1, no error, counter<POLL_MAX: go back to RD.
  - Poll mode, counter==POLL_MAX with busy still set: err=1, go to RESP.
  - All other cases: go to RESP.
- RESP: `rsp_valid`=1 for one cycle, then go to IDLE.
- Address arithmetic is 32-bit, and the offset is zero-extended.

## Timing
- Reset values:
  - All `*valid` and `*ready` outputs are 0, except `req_ready`=1 from the first cycle after reset.
  - `awaddr`, `araddr`, `wdata`, `wstrb`, `rsp_data` and `rsp_err` are 0.
- Accept edge at cycle 0. The slave request appears in cycle 1.
- With zero-wait slave handshakes:
  - Plain write: `rsp_valid` in cycle 3.
  - Plain read: `rsp_valid` in cycle 3.
  - Each poll iteration adds 2 cycles.
- `rsp_valid` is asserted in the cycle after the final `bvalid` or `rvalid` handshake. `req_ready` returns in the cycle after `rsp_valid`.
- AXI `valid`s are never withdrawn before their handshake, and address/data stay stable while valid.
- Reset mid-transaction: all valids and readies are 0 on the next edge, with no response. `spi_axi_if` shares `aresetn`, so no orphan transaction remains.

## Configuration
- Macro: `QSPI_SEQ_POLL_EN`.
  - Defined: poll bit honoured, poll counter and STAT_OFF path built.
  - Undefined: `req_cmd[13]` ignored, a write always goes BRESP→RESP, no poll counter, `rsp_data`=0 for writes.

## Test plan
- Write, offset 3, data 0x80, poll=0 → `awaddr`=0x1fff0303, `wstrb`=16'h0008, `wdata[31:24]`=0x80 (all other bits 0); bresp=0 → `rsp_valid` in cycle 3, `rsp_err`=0.
- Read, offset 2, slave `rdata[23:16]`=0x5A → `araddr`=0x1fff0302, `rsp_data`=0x5A, `rsp_err`=0.
- Write, offset 0, data 0x01, poll=1; status reads return 0x01, 0x01, 0x00 → three reads of 0x1fff0302, then `rsp_data`=0x00, `rsp_err`=0.
- Poll timeout: POLL_MAX=4, status always 0x01 → exactly 4 reads, `rsp_err`=1.
- Error and handshake skew: bresp=2'b10 on a poll=1 write → `rsp_err`=1 with no AR issued. Separately, `wready` one cycle before `awready` → `wvalid` drops first and a single BRESP follows.
- Reset mid-op: assert `aresetn`=0 in BRESP → all AXI valids/readies 0 on the next edge, no `rsp_valid`; after release `req_ready`=1 and the next command runs normally.
